// File: rtl/tdm_demultiplexer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdm_demultiplexer                                             |
// | Purpose  : Rebuilds CHANNELS parallel lanes from a framed serial stream, |
// |            publishing each complete frame atomically. Optional macro     |
// |            TDM_SYNC_CHECK_EN enables marker checking and resync.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tdm_demultiplexer #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sync,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          s,
  output logic                      locked,
  output logic                      sync_err
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] C_LAST_SLOT = SEL_W'(CHANNELS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [SEL_W-1:0]            r_s;
  logic [SEL_W-1:0]            w_s_nxt;
  // The last slot bypasses the shadow and goes straight to the output.
  logic [WIDTH-1:0]            r_shadow [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0]   r_out;
  logic                        r_out_valid;
  logic                        w_wr_en;
  logic [SEL_W-1:0]            w_wr_idx;
  logic                        w_pub;
  logic [CHANNELS*WIDTH-1:0]   w_frame;
`ifdef TDM_SYNC_CHECK_EN
  logic                        r_sync_err;
  logic                        w_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_pub       = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
    w_err       = 1'b0;
`endif
    case (r_state)
      HUNT: begin
        if (in_valid && in_sync) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = '0;
          w_s_nxt     = SEL_W'(1);
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid) begin
`ifdef TDM_SYNC_CHECK_EN
          if (in_sync && (r_s != '0)) begin
            // Early marker: abandon the partial frame and restart at slot 0.
            w_err    = 1'b1;
            w_wr_en  = 1'b1;
            w_wr_idx = '0;
            w_s_nxt  = SEL_W'(1);
          end else if (!in_sync && (r_s == '0)) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_s;
            w_pub    = (r_s == C_LAST_SLOT);
            w_s_nxt  = w_pub ? '0 : r_s + SEL_W'(1);
          end
`else
          w_wr_en  = 1'b1;
          w_wr_idx = r_s;
          w_pub    = (r_s == C_LAST_SLOT);
          w_s_nxt  = w_pub ? '0 : r_s + SEL_W'(1);
`endif
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_comb begin
    w_frame = '0;
    for (int k = 0; k < CHANNELS - 1; k++) begin
      w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
    end
    w_frame[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= HUNT;
      r_s         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < CHANNELS - 1; k++) begin
        r_shadow[k] <= '0;
      end
`ifdef TDM_SYNC_CHECK_EN
      r_sync_err  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_out_valid <= w_pub;
      if (w_pub) begin
        r_out <= w_frame;
      end
      for (int k = 0; k < CHANNELS - 1; k++) begin
        if (w_wr_en && (w_wr_idx == SEL_W'(k))) begin
          r_shadow[k] <= in_data;
        end
      end
`ifdef TDM_SYNC_CHECK_EN
      r_sync_err  <= w_err;
`endif
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign locked    = (r_state == LOCKED);
`ifdef TDM_SYNC_CHECK_EN
  assign sync_err  = r_sync_err;
`else
  assign sync_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demultiplexer.sv
`default_nettype none
// Directed bench for tdm_demultiplexer (WIDTH=1, CHANNELS=4); expectations hand-computed.
module tb_tdm_demultiplexer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [0:0] in_data;
  logic       in_sync;
  logic [3:0] out;
  logic       out_valid;
  logic [1:0] s;
  logic       locked;
  logic       sync_err;

  int n_vec;
  int n_err;

  tdm_demultiplexer #(.WIDTH(1), .CHANNELS(4), .SEL_W(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sync  (in_sync),
    .out      (out),
    .out_valid(out_valid),
    .s        (s),
    .locked   (locked),
    .sync_err (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, then sample #1 after the accepting edge.
  task automatic step(input logic v, input logic d, input logic sy, input logic r);
    @(negedge clock);
    reset    = r;
    in_valid = v;
    in_data  = d;
    in_sync  = sy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_sync = 1'b0;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_out", out, 4'b0000);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    step(0, 0, 0, 0);

    // Basic frame 0,1,0,1
    step(1, 0, 1, 0);
    check("f1_locked", locked, 1);
    check("f1_s1", s, 1);
    check("f1_nv1", out_valid, 0);
    step(1, 1, 0, 0);
    check("f1_s2", s, 2);
    step(1, 0, 0, 0);
    check("f1_s3", s, 3);
    check("f1_nv3", out_valid, 0);
    step(1, 1, 0, 0);
    check("f1_out", out, 4'b1010);
    check("f1_valid", out_valid, 1);
    check("f1_s_wrap", s, 0);
    step(0, 0, 0, 0);
    check("f1_valid_pulse", out_valid, 0);
    check("f1_out_hold", out, 4'b1010);

    // Unsynced samples in HUNT are dropped
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("hunt_locked", locked, 0);
    check("hunt_s", s, 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("hunt_out", out, 4'b0001);
    check("hunt_valid", out_valid, 1);

    // Gaps within a frame
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    check("gap_s_before", s, 2);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check("gap_s_hold", s, 2);
    check("gap_nv", out_valid, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("gap_out", out, 4'b1111);
    check("gap_valid", out_valid, 1);

    // Marker arriving at slot 2
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    check("rs_s2", s, 2);
    step(1, 0, 1, 0);
`ifdef TDM_SYNC_CHECK_EN
    check("rs_err", sync_err, 1);
    check("rs_s", s, 1);
    check("rs_nv", out_valid, 0);
    check("rs_out_hold", out, 4'b1111);
    step(1, 1, 0, 0);
    check("rs_err_pulse", sync_err, 0);
    step(1, 1, 0, 0);
    check("rs_nv_aborted", out_valid, 0);
    step(1, 1, 0, 0);
    check("rs_out", out, 4'b1110);
    check("rs_valid", out_valid, 1);
`else
    check("rs_noerr", sync_err, 0);
    check("rs_s_free", s, 3);
    step(1, 1, 0, 0);
    check("rs_out_free", out, 4'b1001);
    check("rs_valid_free", out_valid, 1);
`endif

    // Reset mid-frame
    step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("mr_pre_out", out, 4'b1100);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    check("mr_out", out, 4'b0000);
    check("mr_s", s, 0);
    check("mr_locked", locked, 0);
    check("mr_nv", out_valid, 0);
    step(1, 1, 0, 0);
    check("mr_tail_nv", out_valid, 0);
    check("mr_tail_s", s, 0);

    // Missing marker at slot 0 after a complete frame
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    check("mm_out", out, 4'b0110);
    check("mm_valid", out_valid, 1);
    step(1, 1, 0, 0);
`ifdef TDM_SYNC_CHECK_EN
    check("mm_err", sync_err, 1);
    check("mm_locked", locked, 0);
    check("mm_s", s, 0);
    step(0, 0, 0, 0);
    check("mm_err_pulse", sync_err, 0);
    step(1, 1, 0, 0);
    check("mm_hunt_drop", s, 0);
`else
    check("mm_noerr", sync_err, 0);
    check("mm_locked", locked, 1);
    check("mm_s", s, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("mm_out_slot0", out, 4'b0001);
    check("mm_valid2", out_valid, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
